apb_cmd_master: RTL and testbench
=================================

# apb_cmd_master

Command-driven APB initiator that lets the USB host reach the register bank. It pops 32-bit command words from the USB receive FIFO (first-word-fall-through) and issues one APB transfer per command on the register bus. Read results go back into the USB transmit FIFO. It sits between the USB FIFO bridge and the APB completer, replacing CPU-sourced APB traffic when the host owns the bus.

## Interface
Parameters:
- ADDR_W, 40: APB address width; header address is zero-extended to this width.
- TIMEOUT, 255: maximum ACCESS cycles without pready before abort; legal range 1..65535.
- ERR_WORD, 32'hDEAD_BEEF: response word returned for a timed-out read.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd_data  in  32  head word of command FIFO, valid when !cmd_empty
- cmd_empty  in  1  command FIFO empty
- cmd_rd_en  out  1  pop command FIFO; combinational
- rsp_data  out  32  response word, registered
- rsp_wr_en  out  1  push response FIFO, one-cycle pulse, registered
- rsp_full  in  1  response FIFO full
- psel, penable, pwrite  out  1 each  APB control, registered
- paddr  out  ADDR_W  APB address, registered, bits [1:0] always 0
- pwdata  out  32  APB write data, registered
- prdata  in  32  APB read data
- pready  in  1  APB ready; tie high for zero-wait completers
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky timeout flag
- err_clr  in  1  clears err; a timeout in the same cycle wins

## Operation
Command format:
- header[31] = 1 for write, 0 for read.
- header[15:2] = word address; header[30:16] and header[1:0] are ignored.
- A write carries a second word, the write data. A read is header only.

States:
- IDLE: cmd_rd_en = !cmd_empty. On a pop, latch paddr and pwrite from the header. A write goes to DATA; a read goes to SETUP.
- DATA: cmd_rd_en = !cmd_empty. On a pop, latch pwdata and go to SETUP. Waits indefinitely while the FIFO is empty.
- SETUP: psel=1, penable=0. Always moves to ACCESS.
- ACCESS: psel=1, penable=1.
  - On pready: a read captures prdata into rsp_data and goes to RESP; a write goes to IDLE.
  - If the wait counter reaches TIMEOUT with no pready: set err. A read loads ERR_WORD and goes to RESP; a write goes to IDLE.
- RESP: when !rsp_full, pulse rsp_wr_en for one cycle and go to IDLE. Otherwise hold.

Rules:
- paddr, pwrite and pwdata are stable from SETUP through the end of ACCESS.
- The wait counter clears on entry to SETUP and counts ACCESS cycles with pready low.
- Only one transfer is outstanding at a time. No command is popped outside IDLE and DATA.
- Writes produce no response word.
- Reset values: psel=penable=pwrite=0, paddr=0, pwdata=0, rsp_data=0, rsp_wr_en=0, err=0, state IDLE.
- Reset mid-operation: APB control drops at the next edge with no completion. Any partially consumed command is discarded; host software must resync by draining.

## Timing
Latency, with the header pop at cycle 0:
- Read, pready=1: SETUP at 1, ACCESS at 2, rsp_wr_en at 3, back in IDLE at 4. Next header pop at cycle 4 gives 4 cycles per read.
- Write, data present: data pop at 1, SETUP at 2, ACCESS at 3, IDLE at 4. 4 cycles per write.
- Each pready-low cycle adds 1 cycle.
- rsp_full held high stalls RESP with rsp_data stable.
- Timeout: with pready stuck low, ACCESS lasts exactly TIMEOUT cycles. err rises on the edge that leaves ACCESS.
- cmd_rd_en is asserted only in IDLE/DATA while !cmd_empty, and cmd_data is sampled in that same cycle.

## Structure
Package apb_cmd_pkg holds:
- the state enum (IDLE, DATA, SETUP, ACCESS, RESP)
- the header field positions: CMD_WR_BIT=31, CMD_ADDR_MSB=15, CMD_ADDR_LSB=2
- the default ERR_WORD

No sub-module; the timeout counter is inline. The block targets 150–250 lines.

## Test plan
- Write then read: push {32'h8000_0000, 32'h0000_0003}, then 32'h0000_0000, into an APB model register. APB write of 3 to address 0x000, then a response word of 3 at cycle 3 after the read header pop.
- Back-to-back reads: 8 read headers queued. psel/penable follow the SETUP/ACCESS sequence each time, 8 responses in order, 4-cycle spacing, no lost or duplicate pops.
- Write data starvation: header pushed, data pushed 10 cycles later. State stays in DATA with psel=0, then the transfer completes with correct pwdata.
- Wait states: completer holds pready low 3 cycles. ACCESS lasts 4 cycles, paddr/pwdata stable throughout, correct prdata captured.
- Timeout and errors:
  - TIMEOUT=8 with pready stuck low on a read: ACCESS lasts exactly 8 cycles, response is 0xDEADBEEF, err=1.
  - err_clr alone clears err; err_clr coinciding with a new timeout leaves err=1.
- Backpressure and reset:
  - rsp_full high 5 cycles during RESP: no push, rsp_data held, pushed once on release.
  - reset asserted in ACCESS: psel=0 and every output at its reset value the next cycle.

Source files
------------

// File: rtl/apb_cmd_pkg.sv
// rtl/apb_cmd_pkg.sv - shared types and command header layout for apb_cmd_master
package apb_cmd_pkg;

    // Controller states: command fetch (IDLE/DATA), APB phases, response push
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    // Header word layout
    localparam int CMD_WR_BIT   = 31;
    localparam int CMD_ADDR_MSB = 15;
    localparam int CMD_ADDR_LSB = 2;

    // Response word returned when a read never sees pready
    localparam logic [31:0] DEFAULT_ERR_WORD = 32'hDEAD_BEEF;

endpackage

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - FIFO-command-driven APB initiator with read responses and timeout
module apb_cmd_master
    import apb_cmd_pkg::*;
#(
    parameter int          ADDR_W   = 40,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_WORD = DEFAULT_ERR_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       cmd_data,
    input  logic              cmd_empty,
    output logic              cmd_rd_en,
    output logic [31:0]       rsp_data,
    output logic              rsp_wr_en,
    input  logic              rsp_full,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [31:0]       pwdata,
    input  logic [31:0]       prdata,
    input  logic              pready,
    output logic              busy,
    output logic              err,
    input  logic              err_clr
);

    // Last wait-counter value before the abort fires; ACCESS then lasts TIMEOUT cycles
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic                w_pop;
    logic                w_timeout;
    logic [15:0]         r_wait_cnt;
    logic                r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_paddr;
    logic [31:0]         r_pwdata;
    logic [31:0]         r_rsp_data;
    logic                r_rsp_wr_en;
    logic                r_err;
    logic                w_unused_hdr_bits;

    // Header bits outside the write flag and word address carry no meaning
    assign w_unused_hdr_bits = ^{cmd_data[30:CMD_ADDR_MSB+1], cmd_data[CMD_ADDR_LSB-1:0]};

    // Next-state, FIFO pop and timeout decode
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pop = !cmd_empty;
                if (w_pop) begin
                    w_next_state = cmd_data[CMD_WR_BIT] ? ST_DATA : ST_SETUP;
                end
            end
            ST_DATA: begin
                w_pop = !cmd_empty;
                if (w_pop) begin
                    w_next_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    w_next_state = r_pwrite ? ST_IDLE : ST_RESP;
                end else if (r_wait_cnt == TIMEOUT_CNT) begin
                    w_timeout    = 1'b1;
                    w_next_state = r_pwrite ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                // The push pulse is already on the bus this cycle, so the word is delivered
                if (r_rsp_wr_en) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // APB control and transfer attributes, registered from the upcoming state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
        end else begin
            r_psel    <= (w_next_state == ST_SETUP) || (w_next_state == ST_ACCESS);
            r_penable <= (w_next_state == ST_ACCESS);
            if ((r_state == ST_IDLE) && w_pop) begin
                r_paddr  <= ADDR_W'({cmd_data[CMD_ADDR_MSB:CMD_ADDR_LSB], 2'b00});
                r_pwrite <= cmd_data[CMD_WR_BIT];
            end
            if ((r_state == ST_DATA) && w_pop) begin
                r_pwdata <= cmd_data;
            end
        end
    end

    // Wait counter: zeroed going into SETUP, counts ACCESS cycles without pready
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (w_next_state == ST_SETUP) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_ACCESS) && !pready) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end

    // Read response capture and push; the push is decided one cycle ahead so it is a register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_data  <= '0;
            r_rsp_wr_en <= 1'b0;
        end else begin
            if ((r_state == ST_ACCESS) && !r_pwrite) begin
                if (pready) begin
                    r_rsp_data <= prdata;
                end else if (w_timeout) begin
                    r_rsp_data <= ERR_WORD;
                end
            end
            r_rsp_wr_en <= (w_next_state == ST_RESP) && !rsp_full;
        end
    end

    // Sticky timeout flag; a new timeout takes priority over a clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign cmd_rd_en = w_pop && !reset;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign rsp_data  = r_rsp_data;
    assign rsp_wr_en = r_rsp_wr_en;
    assign busy      = (r_state != ST_IDLE);
    assign err       = r_err;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - randomized self-checking bench for apb_cmd_master
module tb_apb_cmd_master;

    localparam int          ADDR_W   = 40;
    localparam int          TIMEOUT  = 8;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       cmd_data = 32'h0;
    logic              cmd_empty = 1'b1;
    logic              cmd_rd_en;
    logic [31:0]       rsp_data;
    logic              rsp_wr_en;
    logic              rsp_full = 1'b0;
    logic              psel, penable, pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready = 1'b1;
    logic              busy, err;
    logic              err_clr = 1'b0;

    always #5 clk = ~clk;

    apb_cmd_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .ERR_WORD(ERR_WORD)) dut (
        .clk(clk), .reset(reset),
        .cmd_data(cmd_data), .cmd_empty(cmd_empty), .cmd_rd_en(cmd_rd_en),
        .rsp_data(rsp_data), .rsp_wr_en(rsp_wr_en), .rsp_full(rsp_full),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .busy(busy), .err(err), .err_clr(err_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h required %0h", tag, got, exp);
        end
    endtask

    // Command FIFO contents, word kinds (0 read hdr, 1 write hdr, 2 data), reference model
    logic [31:0] cmd_q[$];
    int          kind_q[$];
    logic [31:0] bank    [0:16383];
    logic [31:0] ref_mem [0:16383];
    logic [72:0] exp_xfer[$];
    logic [31:0] exp_rsp[$];

    int          cyc = 0;
    int          pready_mode = 0;
    int          wait_n = 0;
    int          acc_cnt = 0;
    int          last_access_len = 0;
    int          acc_done_cnt = 0;
    int          push_cnt = 0;
    int          prev_hdr_cyc = -1;
    int          last_rd_hdr_cyc = 0;
    bit          chk_timing = 0;
    bit          stab_bad = 0;
    bit          rand_bp = 0;
    bit          force_full = 0;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wd;
    logic              cap_wr;

    assign prdata = bank[paddr[15:2]];

    // FIFO head presented to the DUT changes only just after a clock edge
    always @(posedge clk) begin
        cyc++;
        #1;
        cmd_empty = (cmd_q.size() == 0);
        cmd_data  = cmd_empty ? 32'h0 : cmd_q[0];
    end

    // Response FIFO full flag: forced or random backpressure
    always begin
        @(negedge clk);
        #1;
        rsp_full = force_full | (rand_bp && ($urandom_range(0, 3) == 0));
    end

    // Completer model, protocol observation and scoreboard, evaluated mid-cycle
    always @(negedge clk) begin
        logic [31:0] w;
        int k;
        if (psel && penable) begin
            acc_cnt++;
            if (paddr !== cap_addr || pwdata !== cap_wd || pwrite !== cap_wr) stab_bad = 1;
            case (pready_mode)
                1:       pready = (acc_cnt > 3) ? 1'b1 : 1'($urandom_range(0, 1));
                2:       pready = 1'b0;
                3:       pready = (acc_cnt > wait_n);
                default: pready = 1'b1;
            endcase
        end else begin
            if (acc_cnt != 0) begin
                last_access_len = acc_cnt;
                acc_done_cnt++;
            end
            acc_cnt = 0;
            if (penable) stab_bad = 1;
            if (psel) begin
                cap_addr = paddr;
                cap_wd   = pwdata;
                cap_wr   = pwrite;
            end
            pready = (pready_mode != 2);
        end
        if (cmd_rd_en) begin
            if (cmd_q.size() == 0) begin
                check("pop_when_empty", 1, 0);
            end else begin
                w = cmd_q.pop_front();
                k = kind_q.pop_front();
                if (k != 2) begin
                    if (chk_timing && prev_hdr_cyc >= 0) check("hdr_spacing", cyc - prev_hdr_cyc, 4);
                    prev_hdr_cyc = cyc;
                    if (k == 0) last_rd_hdr_cyc = cyc;
                end
            end
        end
        if (psel && penable && pready) begin
            if (exp_xfer.size() == 0) check("xfer_unexpected", 1, 0);
            else check("xfer", {pwrite, paddr, pwrite ? pwdata : prdata}, exp_xfer.pop_front());
            if (pwrite) bank[paddr[15:2]] = pwdata;
        end
        if (rsp_wr_en) begin
            push_cnt++;
            check("push_while_full", rsp_full, 0);
            if (exp_rsp.size() == 0) check("rsp_unexpected", 1, 0);
            else check("rsp_data", rsp_data, exp_rsp.pop_front());
            if (chk_timing) check("rd_latency", cyc - last_rd_hdr_cyc, 3);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic void push_cmd(input logic [31:0] w, input int kind);
        cmd_q.push_back(w);
        kind_q.push_back(kind);
    endfunction

    function automatic logic [ADDR_W-1:0] word_addr(input logic [13:0] wa);
        return ADDR_W'(wa) << 2;
    endfunction

    task automatic model_write(input logic [13:0] wa, input logic [31:0] d, input int gap,
                               input bit junk, input bit starve);
        logic [31:0] hdr;
        hdr = {1'b1, junk ? 15'($urandom) : 15'h0, wa, junk ? 2'($urandom) : 2'b00};
        push_cmd(hdr, 1);
        ref_mem[wa] = d;
        exp_xfer.push_back({1'b1, word_addr(wa), d});
        if (starve) begin
            step(3);
            for (int i = 0; i < 10; i++) begin
                check("starve_busy", busy, 1);
                check("starve_psel", psel, 0);
                step(1);
            end
        end else if (gap > 0) begin
            step(gap);
        end
        push_cmd(d, 2);
    endtask

    task automatic model_read(input logic [13:0] wa, input bit tmo, input bit junk);
        logic [31:0] hdr;
        hdr = {1'b0, junk ? 15'($urandom) : 15'h0, wa, junk ? 2'($urandom) : 2'b00};
        push_cmd(hdr, 0);
        if (tmo) begin
            exp_rsp.push_back(ERR_WORD);
        end else begin
            exp_xfer.push_back({1'b0, word_addr(wa), ref_mem[wa]});
            exp_rsp.push_back(ref_mem[wa]);
        end
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while ((cmd_q.size() != 0 || busy || exp_rsp.size() != 0 || exp_xfer.size() != 0)
               && n < limit) begin
            step(1);
            n++;
        end
        check(tag, n < limit, 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_psel"}, psel, 0);
        check({tag, "_penable"}, penable, 0);
        check({tag, "_pwrite"}, pwrite, 0);
        check({tag, "_paddr"}, paddr, 0);
        check({tag, "_pwdata"}, pwdata, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_rsp_wr_en"}, rsp_wr_en, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cmd_rd_en"}, cmd_rd_en, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [13:0] a;
        logic [31:0] d;
        int d0, n, pc0;

        for (int i = 0; i < 16384; i++) begin
            d = $urandom;
            bank[i]    = d;
            ref_mem[i] = d;
        end
        step(3);
        check_reset_state("reset");
        reset = 1'b0;
        step(2);

        // Write 3 to word 0, then read it back, with exact cycle timing
        prev_hdr_cyc = -1;
        chk_timing   = 1;
        model_write(14'd0, 32'h0000_0003, 0, 0, 0);
        model_read(14'd0, 0, 0);
        wait_idle("drain_wr_rd", 200);

        // Eight queued reads, back to back
        prev_hdr_cyc = -1;
        for (int i = 0; i < 8; i++) model_read(14'($urandom), 0, 1);
        wait_idle("drain_b2b", 400);
        chk_timing = 0;
        check("b2b_access_len", last_access_len, 1);

        // Write data arriving long after its header
        model_write(14'h1234, 32'hA5A5_0F0F, 0, 1, 1);
        wait_idle("drain_starve", 200);

        // Three wait states on a read and on a write
        pready_mode = 3;
        wait_n      = 3;
        model_read(14'h0055, 0, 1);
        wait_idle("drain_ws_rd", 200);
        check("ws_rd_access_len", last_access_len, 4);
        model_write(14'h0AAA, $urandom, 0, 1, 0);
        wait_idle("drain_ws_wr", 200);
        check("ws_wr_access_len", last_access_len, 4);
        check("ws_stable", stab_bad, 0);

        // Read timeout
        pready_mode = 2;
        model_read(14'h0777, 1, 1);
        wait_idle("drain_tmo", 200);
        check("tmo_access_len", last_access_len, TIMEOUT);
        check("tmo_err_set", err, 1);

        // err_clr alone
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("err_clr_alone", err, 0);
        step(1);
        check("err_stays_clear", err, 0);

        // err_clr held through a timeout: the timeout wins on its edge
        err_clr = 1'b1;
        d0 = acc_done_cnt;
        n  = 0;
        model_read(14'h0123, 1, 0);
        while (acc_done_cnt == d0 && n < 100) begin
            step(1);
            n++;
            if (acc_cnt == 1) check("err_clr_during_access", err, 0);
        end
        check("tmo2_seen", n < 100, 1);
        check("tmo2_access_len", last_access_len, TIMEOUT);
        check("err_set_wins", err, 1);
        err_clr = 1'b0;
        wait_idle("drain_tmo2", 200);
        pready_mode = 0;

        // Response backpressure while in RESP
        force_full = 1;
        a = 14'h0321;
        d = ref_mem[a];
        model_read(a, 0, 1);
        step(7);
        pc0 = push_cnt;
        for (int i = 0; i < 5; i++) begin
            check("bp_no_push", rsp_wr_en, 0);
            check("bp_rsp_held", rsp_data, d);
            check("bp_busy", busy, 1);
            step(1);
        end
        force_full = 0;
        wait_idle("drain_bp", 200);
        check("bp_one_push", push_cnt - pc0, 1);

        // Random mix of reads/writes with random wait states, gaps and backpressure
        rand_bp     = 1;
        pready_mode = 1;
        for (int i = 0; i < 150; i++) begin
            a = 14'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) model_write(a, $urandom, $urandom_range(0, 2), 1, 0);
            else model_read(a, 0, 1);
            if ($urandom_range(0, 3) == 0) step($urandom_range(1, 4));
        end
        rand_bp = 0;
        wait_idle("drain_random", 6000);
        pready_mode = 0;
        check("random_stable", stab_bad, 0);
        check("random_no_timeout_err_kept", err, 1);

        // Reset in the middle of ACCESS
        pready_mode = 2;
        model_read(14'h0042, 1, 0);
        n = 0;
        while (!(psel && penable) && n < 50) begin
            step(1);
            n++;
        end
        check("reached_access", n < 50, 1);
        reset = 1'b1;
        step(1);
        check_reset_state("midreset");
        reset = 1'b0;
        cmd_q.delete();
        kind_q.delete();
        exp_rsp.delete();
        exp_xfer.delete();
        pready_mode = 0;
        step(3);
        check("post_reset_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
